// File: rtl/pipe_hazard_unit_if.sv
// Decode/Execute hazard-control bundle for pipe_hazard_unit; perf counters exist only with HAZARD_PERF_CNT_EN.
// master = pipeline datapath side, slave = hazard unit side.
interface pipe_hazard_unit_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic [REG_ADDR_WIDTH-1:0] rs1D;
  logic [REG_ADDR_WIDTH-1:0] rs2D;
  logic                      use_rs1D;
  logic                      use_rs2D;
  logic [REG_ADDR_WIDTH-1:0] rdD;
  logic                      RegWriteD;
  logic                      MEMReadD;
  logic                      validD;
  logic                      branch_takenE;

  logic                      stallF;
  logic                      stallD;
  logic                      flushD;
  logic                      flushE;
  logic [1:0]                fwdAE;
  logic [1:0]                fwdBE;
  logic [REG_ADDR_WIDTH-1:0] rdM;
  logic [REG_ADDR_WIDTH-1:0] rdW;
  logic                      RegWriteW;

`ifdef HAZARD_PERF_CNT_EN
  logic [DATA_WIDTH-1:0]     stall_cnt;
  logic [DATA_WIDTH-1:0]     flush_cnt;

  modport master (
    output rs1D, rs2D, use_rs1D, use_rs2D, rdD, RegWriteD, MEMReadD, validD, branch_takenE,
    input  stallF, stallD, flushD, flushE, fwdAE, fwdBE, rdM, rdW, RegWriteW,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1D, rs2D, use_rs1D, use_rs2D, rdD, RegWriteD, MEMReadD, validD, branch_takenE,
    output stallF, stallD, flushD, flushE, fwdAE, fwdBE, rdM, rdW, RegWriteW,
    output stall_cnt, flush_cnt
  );
`else
  // Counter width has no user when the counters are compiled out.
  logic unused_data_width;
  assign unused_data_width = (DATA_WIDTH > 0);

  modport master (
    output rs1D, rs2D, use_rs1D, use_rs2D, rdD, RegWriteD, MEMReadD, validD, branch_takenE,
    input  stallF, stallD, flushD, flushE, fwdAE, fwdBE, rdM, rdW, RegWriteW
  );

  modport slave (
    input  rs1D, rs2D, use_rs1D, use_rs2D, rdD, RegWriteD, MEMReadD, validD, branch_takenE,
    output stallF, stallD, flushD, flushE, fwdAE, fwdBE, rdM, rdW, RegWriteW
  );
`endif
endinterface

// File: rtl/pipe_hazard_unit.sv
// Load-use stall, taken-branch flush and E-stage operand forwarding; HAZARD_PERF_CNT_EN adds stall/flush counters.
// Hazard/forward outputs are combinational (0 cycles); tags advance every edge, no backpressure beyond stallF/stallD.
module pipe_hazard_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_unit_if.slave hz
);

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      regwrite;
    logic                      memread;
  } tag_t;

  typedef struct packed {
    tag_t                      t;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic                      use_rs1;
    logic                      use_rs2;
  } etag_t;

  etag_t e_q, e_d;
  tag_t  m_q, m_d;
  tag_t  w_q, w_d;

  logic lu;
  logic stall_f, stall_d, flush_d, flush_e;

  // A producer tag can only source a forward if it really writes a non-x0 register.
  function automatic logic writes_reg(input tag_t t, input logic [REG_ADDR_WIDTH-1:0] rs);
    return t.valid && t.regwrite && (t.rd != '0) && (t.rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic                      use_rs,
    input tag_t                      m,
    input tag_t                      w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs && writes_reg(m, rs)) begin
      sel = 2'b10;
    end else if (use_rs && writes_reg(w, rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    lu = e_q.t.valid && e_q.t.memread && (e_q.t.rd != '0) && hz.validD &&
         ((hz.use_rs1D && (hz.rs1D == e_q.t.rd)) ||
          (hz.use_rs2D && (hz.rs2D == e_q.t.rd)));
  end

  // A taken branch kills the Decode instruction anyway, so it overrides any load-use stall.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (hz.branch_takenE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    e_d.t.valid    = hz.validD && !flush_e;
    e_d.t.rd       = hz.rdD;
    e_d.t.regwrite = hz.RegWriteD;
    e_d.t.memread  = hz.MEMReadD;
    e_d.rs1        = hz.rs1D;
    e_d.rs2        = hz.rs2D;
    e_d.use_rs1    = hz.use_rs1D;
    e_d.use_rs2    = hz.use_rs2D;
    m_d            = e_q.t;
    w_d            = m_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign hz.stallF    = stall_f;
  assign hz.stallD    = stall_d;
  assign hz.flushD    = flush_d;
  assign hz.flushE    = flush_e;
  assign hz.fwdAE     = fwd_sel(e_q.rs1, e_q.use_rs1, m_q, w_q);
  assign hz.fwdBE     = fwd_sel(e_q.rs2, e_q.use_rs2, m_q, w_q);
  assign hz.rdM       = m_q.rd;
  assign hz.rdW       = w_q.rd;
  assign hz.RegWriteW = w_q.valid && w_q.regwrite;

  // Load flags ride along to M/W for the datapath's benefit; hazard logic only needs E's.
  logic unused_tag_bits;
  assign unused_tag_bits = m_q.memread ^ w_q.memread;

`ifdef HAZARD_PERF_CNT_EN
  logic [DATA_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [DATA_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_d) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_d || flush_e) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  logic unused_data_width;
  assign unused_data_width = (DATA_WIDTH > 0);
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: load-use, forwarding, x0, branch flush, reset and (optionally) counters.
module tb_pipe_hazard_unit;
  localparam int DW  = 32;
  localparam int RAW = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_hazard_unit_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW)) hif ();

  pipe_hazard_unit #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW)) u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_d(input logic v, input int rd, input logic rw, input logic mr,
                         input int rs1, input logic u1, input int rs2, input logic u2);
    logic [31:0] rd_v, rs1_v, rs2_v;
    rd_v  = rd;
    rs1_v = rs1;
    rs2_v = rs2;
    hif.validD    = v;
    hif.rdD       = rd_v[RAW-1:0];
    hif.RegWriteD = rw;
    hif.MEMReadD  = mr;
    hif.rs1D      = rs1_v[RAW-1:0];
    hif.use_rs1D  = u1;
    hif.rs2D      = rs2_v[RAW-1:0];
    hif.use_rs2D  = u2;
    #1;
  endtask

  task automatic nop();
    drive_d(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    hif.branch_takenE = 1'b0;
    nop();
    #1;
    chk("rst_stallF", hif.stallF, 0);
    chk("rst_stallD", hif.stallD, 0);
    chk("rst_flushD", hif.flushD, 0);
    chk("rst_flushE", hif.flushE, 0);
    chk("rst_fwdAE", hif.fwdAE, 0);
    chk("rst_fwdBE", hif.fwdBE, 0);
    chk("rst_RegWriteW", hif.RegWriteW, 0);
    chk("rst_rdW", hif.rdW, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_stall_cnt", hif.stall_cnt, 0);
    chk("rst_flush_cnt", hif.flush_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_release_stallF", hif.stallF, 0);

    // lw x5 then add x6,x5,x1: one bubble, then W forwards to operand A
    drive_d(1, 5, 1, 1, 2, 1, 0, 0);
    chk("lu_empty_E", hif.stallF, 0);
    step();
    drive_d(1, 6, 1, 0, 5, 1, 1, 1);
    chk("lu_stallF", hif.stallF, 1);
    chk("lu_stallD", hif.stallD, 1);
    chk("lu_flushE", hif.flushE, 1);
    chk("lu_flushD", hif.flushD, 0);
    step();
    chk("lu_bubble_no_stall", hif.stallD, 0);
    chk("lu_rdM", hif.rdM, 5);
    step();
    chk("lu_fwdAE_W", hif.fwdAE, 1);
    chk("lu_fwdBE_none", hif.fwdBE, 0);
    chk("lu_RegWriteW", hif.RegWriteW, 1);
    chk("lu_rdW", hif.rdW, 5);

    // addi x5 ; add x5 ; sub x7,x3,x5 -> M wins over W on operand B
    drive_d(1, 5, 1, 0, 1, 1, 0, 0);
    chk("alu_in_E_no_stall", hif.stallD, 0);
    step();
    drive_d(1, 5, 1, 0, 3, 1, 4, 1);
    step();
    drive_d(1, 7, 1, 0, 3, 1, 5, 1);
    step();
    nop();
    chk("prio_fwdBE_M", hif.fwdBE, 2);
    chk("prio_fwdAE_none", hif.fwdAE, 0);

    // lw x0 followed by a reader of x0
    drive_d(1, 0, 1, 1, 0, 0, 0, 0);
    step();
    drive_d(1, 8, 1, 0, 0, 1, 0, 1);
    chk("x0_no_stall", hif.stallF, 0);
    chk("x0_no_flushE", hif.flushE, 0);
    step();
    nop();
    chk("x0_fwdAE", hif.fwdAE, 0);
    chk("x0_fwdBE", hif.fwdBE, 0);

    // matching sources on an invalid Decode slot do not stall
    drive_d(1, 13, 1, 1, 0, 0, 0, 0);
    step();
    drive_d(0, 0, 0, 0, 13, 1, 0, 0);
    chk("lu_needs_validD", hif.stallD, 0);

    // load-use and taken branch together: flush wins, E becomes a bubble
    drive_d(1, 9, 1, 1, 1, 1, 0, 0);
    step();
    drive_d(1, 10, 1, 0, 9, 1, 0, 0);
    hif.branch_takenE = 1'b1;
    #1;
    chk("br_flushD", hif.flushD, 1);
    chk("br_flushE", hif.flushE, 1);
    chk("br_stallF", hif.stallF, 0);
    chk("br_stallD", hif.stallD, 0);
    step();
    hif.branch_takenE = 1'b0;
    nop();
    step();
    chk("br_load_RegWriteW", hif.RegWriteW, 1);
    chk("br_load_rdW", hif.rdW, 9);
    step();
    chk("br_killed_rdW", hif.rdW, 10);
    chk("br_killed_RegWriteW", hif.RegWriteW, 0);

    // back-to-back dependent loads: one bubble each
    drive_d(1, 11, 1, 1, 0, 0, 0, 0);
    step();
    drive_d(1, 12, 1, 1, 11, 1, 0, 0);
    chk("b2b_stall1", hif.stallD, 1);
    step();
    chk("b2b_bubble1", hif.stallD, 0);
    step();
    drive_d(1, 13, 1, 0, 0, 0, 12, 1);
    chk("b2b_stall2", hif.stallD, 1);
    step();
    chk("b2b_bubble2", hif.stallD, 0);
    step();
    nop();
    chk("b2b_fwdBE_W", hif.fwdBE, 1);
`ifdef HAZARD_PERF_CNT_EN
    chk("mid_stall_cnt", hif.stall_cnt, 3);
    chk("mid_flush_cnt", hif.flush_cnt, 4);
`endif

    // reset asserted in the middle of a stall
    drive_d(1, 14, 1, 1, 0, 0, 0, 0);
    step();
    drive_d(1, 15, 1, 0, 14, 1, 0, 0);
    chk("pre_rst_stall", hif.stallF, 1);
    rst = 1'b0;
    #1;
    chk("midrst_stallF", hif.stallF, 0);
    chk("midrst_stallD", hif.stallD, 0);
    chk("midrst_flushE", hif.flushE, 0);
    chk("midrst_flushD", hif.flushD, 0);
    chk("midrst_fwdAE", hif.fwdAE, 0);
    chk("midrst_RegWriteW", hif.RegWriteW, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("midrst_stall_cnt", hif.stall_cnt, 0);
    chk("midrst_flush_cnt", hif.flush_cnt, 0);
`endif
    step();
    nop();
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("post_rst_no_stall", hif.stallD, 0);

    // three load-use stalls then two taken branches
    for (int i = 0; i < 3; i++) begin
      drive_d(1, 20 + i, 1, 1, 0, 0, 0, 0);
      step();
      drive_d(1, 25, 1, 0, 20 + i, 1, 0, 0);
      chk("cnt_seq_stall", hif.stallD, 1);
      step();
      nop();
      step();
    end
    for (int i = 0; i < 2; i++) begin
      hif.branch_takenE = 1'b1;
      #1;
      chk("cnt_seq_flushD", hif.flushD, 1);
      step();
      hif.branch_takenE = 1'b0;
      #1;
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("end_stall_cnt", hif.stall_cnt, 3);
    chk("end_flush_cnt", hif.flush_cnt, 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
